// File: rtl/alu_operand_sequencer.sv
// Operand/result sequencer around an external combinational ALU: captures A, op and B
// from a shared bus, registers the ALU result into Z and returns it by valid/ready.
module alu_operand_sequencer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OPW-1:0]   op_in,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] z_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             op_err,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [OPW-1:0] OP_NOT = OPW'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             op_err_q, op_err_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic [CNTW-1:0]  op_count_q, op_count_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves one unassigned (no latch).
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        z_d        = z_q;
        op_err_d   = op_err_q;
        op_count_d = op_count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    alu_op_d = op_in;
                    alu_a_d  = bus_in;
                    if (op_in == OP_NOT) begin
                        alu_b_d = '0;
                        state_d = EXEC;
                    end else begin
                        state_d = GET_B;
                    end
                end
            end
            GET_B: begin
                if (bus_valid) begin
                    alu_b_d = bus_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The ALU supports only OR, AND and NOT; for any other opcode its output is dropped.
                if (alu_op_q <= OP_NOT) begin
                    z_d      = alu_result;
                    op_err_d = 1'b0;
                end else begin
                    z_d      = '0;
                    op_err_d = 1'b1;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    op_count_d = op_count_q + CNTW'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            z_q         <= '0;
            op_err_q    <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            z_q         <= z_d;
            op_err_q    <= op_err_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign z_out     = z_q;
    assign op_err    = op_err_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a transaction driver predicts every output from the
// opcode semantics; a negedge process compares all outputs against those predictions.
module tb_alu_operand_sequencer;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;
    localparam int CNTW  = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [OPW-1:0]   op_in;
    logic [WIDTH-1:0] bus_in;
    logic             bus_valid;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] z_out;
    logic             res_valid, res_ready, op_err, busy;
    logic [CNTW-1:0]  op_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Expected outputs, maintained by the driver from what it applied.
    logic [WIDTH-1:0] exp_a, exp_b, exp_z;
    logic [OPW-1:0]   exp_op;
    logic             exp_valid, exp_err, exp_busy;
    int               exp_cnt;

    alu_operand_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_in(op_in), .bus_in(bus_in),
        .bus_valid(bus_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .z_out(z_out), .res_valid(res_valid),
        .res_ready(res_ready), .op_err(op_err), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU; unsupported opcodes yield junk the sequencer must drop.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a | alu_b;
            4'd1:    alu_result = alu_a & alu_b;
            4'd2:    alu_result = ~alu_a;
            default: alu_result = alu_a ^ alu_b ^ 32'hA5A5_5A5A;
        endcase
    end

    function automatic logic [WIDTH-1:0] model_result(input logic [OPW-1:0] op,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        case (op)
            4'd0:    return a | b;
            4'd1:    return a & b;
            4'd2:    return ~a;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("alu_a", alu_a, exp_a);
            check("alu_b", alu_b, exp_b);
            check("alu_op", {28'd0, alu_op}, {28'd0, exp_op});
            check("z_out", z_out, exp_z);
            check("res_valid", {31'd0, res_valid}, {31'd0, exp_valid});
            check("op_err", {31'd0, op_err}, {31'd0, exp_err});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("op_count", {28'd0, op_count}, WIDTH'(exp_cnt));
        end
    end

    task automatic clear_exp();
        exp_a = '0; exp_b = '0; exp_z = '0; exp_op = '0;
        exp_valid = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Random activity on inputs that must be ignored in EXEC/HOLD (B capture is closed).
    task automatic noise();
        start     = 1'($urandom);
        op_in     = 4'($urandom);
        bus_in    = $urandom;
        bus_valid = 1'($urandom);
    endtask

    // One full transaction: start, optional B wait, EXEC, backpressure, handshake.
    task automatic do_op(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int dly, input int bp);
        start = 1'b1; op_in = op; bus_in = a;
        bus_valid = 1'($urandom); res_ready = 1'($urandom);
        step();
        exp_a = a; exp_op = op; exp_busy = 1'b1;
        if (op == 4'd2) begin
            exp_b = '0;
        end else begin
            for (int i = 0; i < dly; i++) begin
                start = 1'($urandom); op_in = 4'($urandom); bus_in = $urandom;
                bus_valid = 1'b0; res_ready = 1'($urandom);
                step();
            end
            start = 1'($urandom); op_in = 4'($urandom); bus_in = b; bus_valid = 1'b1;
            step();
            exp_b = b;
        end
        noise(); res_ready = 1'($urandom);
        step();
        exp_z = model_result(op, a, b); exp_err = (op > 4'd2); exp_valid = 1'b1;
        for (int i = 0; i < bp; i++) begin
            noise(); res_ready = 1'b0;
            step();
        end
        noise(); res_ready = 1'b1;
        step();
        exp_valid = 1'b0; exp_busy = 1'b0; exp_cnt = (exp_cnt + 1) % (1 << CNTW);
        start = 1'b0; bus_valid = 1'($urandom); res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; op_in = '0; bus_in = '0;
        bus_valid = 1'b0; res_ready = 1'b0;
        clear_exp();
        repeat (2) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        check("reset_z", z_out, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        reset_n = 1'b1;
        step();

        // OR with B one cycle after start.
        do_op(4'd0, 32'h0000_00F0, 32'h0000_000F, 0, 0);
        check("or_z", z_out, 32'h0000_00FF);
        check("or_cnt", {28'd0, op_count}, 32'd1);
        do_op(4'd1, 32'hFFFF_0000, 32'h1234_5678, 0, 1);
        check("and_z", z_out, 32'h1234_0000);
        do_op(4'd1, 32'hFFFF_0000, 32'h1234_5678, 4, 0);
        check("and_dly_z", z_out, 32'h1234_0000);
        do_op(4'd2, 32'h0F0F_0F0F, 32'h0, 0, 0);
        check("not_z", z_out, 32'hF0F0_F0F0);
        check("not_b", alu_b, 32'h0);
        do_op(4'd5, 32'h1, 32'h2, 0, 0);
        check("ill_z", z_out, 32'h0);
        check("ill_err", {31'd0, op_err}, 32'd1);
        check("ill_cnt", {28'd0, op_count}, 32'd5);
        do_op(4'd0, 32'h0000_1200, 32'h0000_0034, 1, 6);
        check("bp_z", z_out, 32'h0000_1234);
        check("bp_a", alu_a, 32'h0000_1200);

        // Reset in GET_B: the pending operation vanishes and is not counted.
        start = 1'b1; op_in = 4'd0; bus_in = 32'hDEAD_0000; bus_valid = 1'b0;
        step();
        exp_a = 32'hDEAD_0000; exp_op = 4'd0; exp_busy = 1'b1;
        start = 1'b0;
        step();
        #1 reset_n = 1'b0;
        clear_exp();
        #1;
        check("rst_a", alu_a, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_cnt", {28'd0, op_count}, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        do_op(4'd0, 32'h0000_00F0, 32'h0000_000F, 0, 0);
        check("post_rst_z", z_out, 32'h0000_00FF);
        check("post_rst_cnt", {28'd0, op_count}, 32'd1);

        // Counter wrap at CNTW=4.
        for (int i = 0; i < 14; i++) do_op(4'($urandom_range(0, 2)), $urandom, $urandom, 0, 0);
        check("cnt_15", {28'd0, op_count}, 32'd15);
        do_op(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
        check("cnt_wrap", {28'd0, op_count}, 32'd0);
        check("wrap_z", z_out, 32'hF000_F000);

        for (int i = 0; i < 80; i++) begin
            logic [OPW-1:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
            do_op(op, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) step();
        end

        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Sequential front/back stage wrapped around the combinational 32-bit ALU. It accepts an opcode and operands from the shared data bus, holding A in a Y-style register and B in a second register. It presents them plus the opcode to the ALU, captures the ALU result into a Z register, and hands it to the consumer through a valid/ready handshake. It also screens opcodes the ALU does not implement, and counts completed operations.

## Interface
Parameters:
- WIDTH, 32, data/bus width; must match ALU operand width
- OPW, 4, opcode width
- CNTW, 16, width of completed-operation counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- op_in  in  OPW  opcode, captured with start
- bus_in  in  WIDTH  shared data bus; A captured with start, B captured with bus_valid
- bus_valid  in  1  B operand present on bus_in (GET_B only)
- alu_a  out  WIDTH  registered operand A to ALU
- alu_b  out  WIDTH  registered operand B to ALU
- alu_op  out  OPW  registered opcode to ALU
- alu_result  in  WIDTH  combinational result from ALU
- z_out  out  WIDTH  captured result (Z register)
- res_valid  out  1  z_out valid, held until accepted
- res_ready  in  1  consumer accepts result
- op_err  out  1  last operation used an unsupported opcode
- busy  out  1  high in every state except IDLE
- op_count  out  CNTW  completed operations (handshakes), wraps

## Operation
- Supported opcodes: 0 = OR, 1 = AND, 2 = NOT(A). Opcodes 3..15 are illegal.
- States:
  - **IDLE:** busy=0. On start=1, load alu_op<=op_in and alu_a<=bus_in. If op_in==2, go to EXEC and load alu_b<=0. Otherwise go to GET_B.
  - **GET_B:** wait for bus_valid=1, then load alu_b<=bus_in and go to EXEC. start is ignored.
  - **EXEC:** one cycle. If alu_op<=2, then z_out<=alu_result and op_err<=0. Otherwise z_out<=0 and op_err<=1. Go to HOLD.
  - **HOLD:** res_valid=1. z_out and op_err stay stable. When res_ready=1, go to IDLE and op_count<=op_count+1 (mod 2^CNTW).
- start in GET_B, EXEC or HOLD: ignored, no queuing.
- bus_valid outside GET_B: ignored.
- op_err is a registered flag, updated only in EXEC. It stays valid with z_out until the next EXEC.
- alu_a, alu_b and alu_op hold their values after the operation completes, until the next capture.

## Timing
- Reset (async assert, any state): state=IDLE. All outputs 0: alu_a, alu_b, alu_op, z_out, res_valid, op_err, busy, op_count. Reset mid-operation discards the operation and does not count it.
- Reset deassertion: first active edge is the first edge after reset_n rises.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency, binary op with bus_valid in the cycle after start:
  - start sampled at edge 0
  - B sampled at edge 1
  - Z captured at edge 2; res_valid high after edge 2
- Latency, NOT: start at edge 0, Z captured at edge 1.
- ALU path budget: alu_a/alu_b/alu_op register → ALU → Z register, one full cycle.
- res_valid falls after the edge on which res_ready=1 is sampled. The earliest new start is then sampled one edge later (one idle cycle minimum).
- op_count at all-ones wraps to 0 on the next completed handshake.

## Test plan
- Binary ops:
  - OR: start, op=0, A=0x000000F0, then bus_valid with B=0x0000000F → z_out=0x000000FF, op_err=0, res_valid 2 edges after start, op_count=1.
  - AND: op=1, A=0xFFFF0000, B=0x12345678 → z_out=0x12340000.
  - Delay bus_valid 4 cycles in GET_B → busy=1 throughout, result unchanged.
- NOT: op=2, A=0x0F0F0F0F, no bus_valid → z_out=0xF0F0F0F0 one edge after start, alu_b=0.
- Illegal opcode: op=5, A=1, B=2 → z_out=0, op_err=1, res_valid=1. Handshake completes and op_count increments.
- Backpressure: hold res_ready=0 for 6 cycles, pulse start and bus_valid during HOLD with new values → z_out/res_valid stable, alu_a unchanged, start ignored. Raise res_ready → IDLE next edge.
- Reset mid-operation: assert reset_n=0 asynchronously while in GET_B → all outputs 0 immediately, op_count unchanged-from-reset (0). A fresh OR then completes normally.
- Counter wrap: CNTW=4, run 16 back-to-back operations with res_ready=1 → op_count reads 15 then 0.
